// File: rtl/debug_ctrl_pkg.sv
// Shared types and constants for the Avalon-MM debug controller.
package debug_ctrl_pkg;

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StDrain  = 3'd1,
    StHalted = 3'd2,
    StStep   = 3'd3,
    StAccess = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [2:0] AddrCtrl    = 3'd0;
  localparam logic [2:0] AddrStatus  = 3'd1;
  localparam logic [2:0] AddrStepCnt = 3'd2;
  localparam logic [2:0] AddrMemAddr = 3'd3;
  localparam logic [2:0] AddrMemData = 3'd4;
  localparam logic [2:0] AddrPc      = 3'd5;
  localparam logic [2:0] AddrBpAddr  = 3'd6;
  localparam logic [2:0] AddrBpCtrl  = 3'd7;

  localparam int unsigned CtrlHalt   = 0;
  localparam int unsigned CtrlResume = 1;
  localparam int unsigned CtrlStep   = 2;
  localparam int unsigned CtrlMemRd  = 3;
  localparam int unsigned CtrlMemWr  = 4;

  localparam int unsigned StatusBusy = 3;
  localparam int unsigned StatusErr  = 4;

  localparam int unsigned BpEn  = 0;
  localparam int unsigned BpHit = 1;

  // At most one field is set: commands are priority-encoded before use.
  typedef struct packed {
    logic halt;
    logic resume;
    logic step;
    logic mem_rd;
    logic mem_wr;
  } cmd_t;

  function automatic logic is_busy(input state_e s);
    return (s == StDrain) || (s == StStep) || (s == StAccess) || (s == StDone);
  endfunction

endpackage

// File: rtl/debug_ctrl_mm_if.sv
// Avalon-MM slave bus of the debug controller.
interface debug_ctrl_mm_if #(
  parameter int unsigned DATA_W = 32
);
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [2:0]        address;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, write, writedata, read, address,
    input  readdata
  );

  modport slave (
    input  chipselect, write, writedata, read, address,
    output readdata
  );
endinterface

// File: rtl/debug_regfile.sv
// Avalon decode, host-visible registers, command priority encoding and registered readdata.
// DEBUG_BREAKPOINT_EN adds the BP_ADDR/BP_CTRL registers and the PC comparator.
module debug_regfile
  import debug_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MADDR_W = 32,
  parameter int unsigned STEP_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  debug_ctrl_mm_if.slave     bus,
  input  state_e             state,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic               pc_cap,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               rd_cap,
  input  logic               err_set,
  output cmd_t               cmd,
  output logic [STEP_W-1:0]  step_cnt,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               bp_trig
);

  logic              wr, rd;
  logic              err_q;
  logic [DATA_W-1:0] rbuf_q, pc_q, readdata_q, rdata_d;
  logic [DATA_W-1:0] bp_addr_rd, bp_ctrl_rd;

  assign wr = bus.chipselect & bus.write;
  assign rd = bus.chipselect & bus.read;

  always_comb begin
    cmd = '0;
    if (wr && bus.address == AddrCtrl) begin
      if (bus.writedata[CtrlHalt])        cmd.halt   = 1'b1;
      else if (bus.writedata[CtrlResume]) cmd.resume = 1'b1;
      else if (bus.writedata[CtrlStep])   cmd.step   = 1'b1;
      else if (bus.writedata[CtrlMemRd])  cmd.mem_rd = 1'b1;
      else if (bus.writedata[CtrlMemWr])  cmd.mem_wr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      step_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rbuf_q    <= '0;
      pc_q      <= '0;
    end else begin
      // A new error in the same cycle as a host clear stays visible.
      if (err_set) err_q <= 1'b1;
      else if (wr && bus.address == AddrStatus && bus.writedata[StatusErr]) err_q <= 1'b0;
      if (wr && bus.address == AddrStepCnt) step_cnt  <= STEP_W'(bus.writedata);
      if (wr && bus.address == AddrMemAddr) mem_addr  <= MADDR_W'(bus.writedata);
      if (wr && bus.address == AddrMemData) mem_wdata <= bus.writedata;
      if (rd_cap) rbuf_q <= mem_rdata;
      if (pc_cap) pc_q   <= pc_in;
    end
  end

`ifdef DEBUG_BREAKPOINT_EN
  logic [DATA_W-1:0] bp_addr_q;
  logic              bp_en_q, bp_hit_q;

  assign bp_trig = (state == StRun) && bp_en_q && (pc_in == bp_addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      if (wr && bus.address == AddrBpAddr) bp_addr_q <= bus.writedata;
      if (wr && bus.address == AddrBpCtrl) bp_en_q <= bus.writedata[BpEn];
      if (bp_trig) bp_hit_q <= 1'b1;
      else if (wr && bus.address == AddrBpCtrl && bus.writedata[BpHit]) bp_hit_q <= 1'b0;
    end
  end

  assign bp_addr_rd = bp_addr_q;
  assign bp_ctrl_rd = DATA_W'({bp_hit_q, bp_en_q});
`else
  assign bp_trig    = 1'b0;
  assign bp_addr_rd = '0;
  assign bp_ctrl_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      AddrStatus:  rdata_d = DATA_W'({err_q, is_busy(state), state});
      AddrStepCnt: rdata_d = DATA_W'(step_cnt);
      AddrMemAddr: rdata_d = DATA_W'(mem_addr);
      AddrMemData: rdata_d = rbuf_q;
      AddrPc:      rdata_d = pc_q;
      AddrBpAddr:  rdata_d = bp_addr_rd;
      AddrBpCtrl:  rdata_d = bp_ctrl_rd;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  readdata_q <= '0;
    else if (rd) readdata_q <= rdata_d;
  end

  assign bus.readdata = readdata_q;

endmodule

// File: rtl/debug_ctrl_mm.sv
// Avalon-MM debug controller: halt/resume/step of the core and debug memory access.
// Optional breakpoint support is built when DEBUG_BREAKPOINT_EN is defined.
module debug_ctrl_mm
  import debug_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MADDR_W   = 32,
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  debug_ctrl_mm_if.slave      bus,
  input  logic [DATA_W-1:0]   pc_in,
  output logic                debug,
  output logic [N_STAGES-1:0] enable_ext,
  output logic                enable_pc_ext,
  output logic                tx_flag,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned CntW = 32;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  cmd_t                cmd;
  logic                any_cmd, bp_trig, err_set, pc_cap, rd_cap, latch;
  logic [STEP_W-1:0]   step_cnt;
  logic [MADDR_W-1:0]  reg_mem_addr;
  logic [DATA_W-1:0]   reg_mem_wdata;

  debug_regfile #(
    .DATA_W (DATA_W),
    .MADDR_W(MADDR_W),
    .STEP_W (STEP_W)
  ) u_regfile (
    .clk      (CLK),
    .rst_n    (RST_N),
    .bus      (bus),
    .state    (state_q),
    .pc_in    (pc_in),
    .pc_cap   (pc_cap),
    .mem_rdata(mem_rdata),
    .rd_cap   (rd_cap),
    .err_set  (err_set),
    .cmd      (cmd),
    .step_cnt (step_cnt),
    .mem_addr (reg_mem_addr),
    .mem_wdata(reg_mem_wdata),
    .bp_trig  (bp_trig)
  );

  assign any_cmd = |cmd;
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_set = 1'b0;
    pc_cap  = 1'b0;
    rd_cap  = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      StRun: begin
        // Breakpoint and host HALT share one path into DRAIN.
        if (cmd.halt || bp_trig) state_d = StDrain;
        if (any_cmd && !cmd.halt) err_set = 1'b1;
      end
      StDrain: begin
        err_set = any_cmd;
        if (cnt_inc == CntW'(DRAIN_CYC)) begin
          state_d = StHalted;
          pc_cap  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHalted: begin
        if (cmd.resume) begin
          state_d = StRun;
        end else if (cmd.step) begin
          if (step_cnt != '0) state_d = StStep;
          else                err_set = 1'b1;
        end else if (cmd.mem_rd || cmd.mem_wr) begin
          state_d = StAccess;
          latch   = 1'b1;
        end else if (cmd.halt) begin
          err_set = 1'b1;
        end
      end
      StStep: begin
        err_set = any_cmd;
        if (cnt_inc == CntW'(step_cnt)) state_d = StDrain;
        else                            cnt_d   = cnt_inc;
      end
      StAccess: begin
        err_set = any_cmd;
        if (mem_ack) begin
          state_d = StDone;
          rd_cap  = !mem_we;
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          state_d = StHalted;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        err_set = any_cmd;
        state_d = StHalted;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Snapshot so host register writes during ACCESS don't disturb the bus.
      if (latch) begin
        mem_we    <= cmd.mem_wr;
        mem_addr  <= reg_mem_addr;
        mem_wdata <= reg_mem_wdata;
      end
    end
  end

  always_comb begin
    debug         = (state_q != StRun);
    enable_ext    = '0;
    enable_pc_ext = 1'b0;
    unique case (state_q)
      StRun: begin
        enable_ext    = '1;
        enable_pc_ext = 1'b1;
      end
      StDrain: enable_ext = '1;
      StStep: begin
        enable_ext    = '1;
        enable_pc_ext = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req = (state_q == StAccess);
  assign tx_flag = (state_q == StDone);

endmodule

// File: doc/debug_ctrl_mm.md
Name: debug_ctrl_mm

Overview:
- Parametrised Avalon-MM debug controller for the RISC-V core; successor to the single-register debug slave.
- Halts, resumes and single-steps the pipeline through per-stage enables.
- Performs debug memory reads and writes over a request/ack port, and reports core PC and status to the host.
- Sits between the QSYS Avalon fabric and the core's stage-enable and debug-memory ports.

Parameters:
DATA_W, 32, Avalon data, PC and memory data width
MADDR_W, 32, debug memory address width
N_STAGES, 4, number of pipeline stage enables
STEP_W, 16, single-step counter width
DRAIN_CYC, 4, cycles from debug assertion to HALTED (pipeline drain)
TIMEOUT, 255, max cycles to wait for mem_ack before error

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
writedata  in  DATA_W  Avalon write data
read  in  1  Avalon read strobe
address  in  3  Avalon word address
readdata  out  DATA_W  Avalon read data, registered
pc_in  in  DATA_W  current core PC
debug  out  1  core halted/debug indication
enable_ext  out  N_STAGES  per-stage pipeline enables
enable_pc_ext  out  1  PC update enable
tx_flag  out  1  one-cycle pulse when a memory access completes
mem_req  out  1  debug memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MADDR_W  debug memory address
mem_wdata  out  DATA_W  debug memory write data
mem_rdata  in  DATA_W  debug memory read data
mem_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (async, RST_N=0):
  - state=RUN; debug=0; enable_ext=all ones; enable_pc_ext=1.
  - tx_flag=0; mem_req=0; mem_we=0; readdata=0.
  - All registers zero.
  - Reset mid-access drops mem_req immediately.
- Register map (word address):
  - 0 CTRL, W: bit0 HALT, bit1 RESUME, bit2 STEP, bit3 MEM_RD, bit4 MEM_WR. Bits are self-clearing commands; read returns 0.
  - 1 STATUS, R: [2:0] state code, bit3 busy, bit4 err (sticky). W: bit4=1 clears err.
  - 2 STEP_CNT, R/W, STEP_W bits.
  - 3 MEM_ADDR, R/W.
  - 4 MEM_DATA: W loads the write buffer; R returns last read data.
  - 5 PC, R: pc_in captured on entry to HALTED.
  - 6 BP_ADDR, 7 BP_CTRL: used by the optional feature; read 0 without it.
- Avalon access:
  - Write takes effect on the cycle chipselect&write is seen.
  - readdata is valid the cycle after chipselect&read (fixed 1-cycle latency); no waitrequest.
- Command priority when several CTRL bits are set in one write: HALT > RESUME > STEP > MEM_RD > MEM_WR. Lower-priority bits are discarded.
- State codes: RUN=0, DRAIN=1, HALTED=2, STEP=3, ACCESS=4, DONE=5.
- Transitions:
  - RUN --HALT--> DRAIN. debug=1 and enable_pc_ext=0 from the next cycle; stage enables stay on for DRAIN_CYC cycles.
  - DRAIN --counter==DRAIN_CYC--> HALTED. enable_ext=0; PC captured.
  - HALTED --RESUME--> RUN. All enables return to 1 the next cycle.
  - HALTED --STEP with STEP_CNT>0--> STEP. All enables=1 for exactly STEP_CNT cycles, then DRAIN (debug stays 1).
  - HALTED --MEM_RD/MEM_WR--> ACCESS. mem_req=1 with mem_addr, mem_we and mem_wdata stable until mem_ack.
  - ACCESS --mem_ack--> DONE. MEM_DATA captures mem_rdata on a read; tx_flag pulses in DONE.
  - DONE --> HALTED unconditionally, next cycle.
- Error and boundary cases:
  - STEP with STEP_CNT=0: no-op, err=1.
  - Any command not legal in the current state (e.g. MEM_RD in RUN, HALT in HALTED): ignored, err=1.
  - ACCESS without ack after TIMEOUT cycles: mem_req dropped, err=1, return to HALTED, no tx_flag.
  - busy=1 in DRAIN, STEP, ACCESS and DONE.
  - A register write to MEM_ADDR or MEM_DATA during ACCESS is accepted into the register but does not alter outputs in flight; mem_addr and mem_wdata are latched on ACCESS entry.

Optional Feature:
- DEBUG_BREAKPOINT_EN defined:
  - BP_ADDR is writable; BP_CTRL bit0 = enable, bit1 = hit (sticky, write 1 to clear).
  - In RUN, when enable=1 and pc_in==BP_ADDR: hit=1 and an automatic HALT (same path as a host HALT).
  - Host HALT in the same cycle is merged into a single DRAIN.
- Undefined: addresses 6 and 7 read 0 and writes are ignored; no comparator logic.

Decomposition:
- Package debug_ctrl_pkg:
  - state enum (3-bit codes above);
  - register address localparams;
  - CTRL and STATUS bit-index constants.
- Sub-module debug_regfile: Avalon decode, the registers, command pulse generation with priority encoding, and registered readdata.
- The FSM, counters and memory port stay in the top module.

Test Plan:
- Reset: RST_N=0 then 1 -> enable_ext=4'hF, debug=0, STATUS reads 0.
- HALT: write CTRL=1 -> debug=1 next cycle; enable_ext=0 after 4 cycles; STATUS state=2; PC register = pc_in at entry.
- Step: halted, STEP_CNT=3, CTRL=4 -> enable_ext=4'hF for exactly 3 cycles, then drain 4 cycles, back to HALTED.
- Memory read: halted, MEM_ADDR=0x100, CTRL=8, ack after 5 cycles with mem_rdata=0xDEADBEEF -> tx_flag pulses once; MEM_DATA reads 0xDEADBEEF.
- Errors and timeout: STEP_CNT=0 with STEP -> err=1; MEM_WR with no ack -> mem_req drops after 255 cycles, err=1; STATUS write 0x10 clears err.
- Breakpoint (macro on): BP_ADDR=0x40, BP_CTRL=1, pc_in reaches 0x40 -> hit=1, core halts. With the macro off, the same stimulus leaves the core in RUN.
